// File: rtl/ba_register_file.sv
// Two-read / one-write register file with base-address zero gating and a soft-clear sweep FSM.
// Define BA_RF_BYPASS_EN to forward same-cycle write data to a colliding read.
module ba_register_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    input  logic             BAout,
    input  logic             sweep_req,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid,
    output logic             busy,
    output logic             wr_err
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             wr_err_q, wr_err_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_acc;

    assign wr_acc = we && !busy_q;

    // Gating is applied after any forwarding so BAout still hides register 0.
    function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] w;
        w = mem_q[ra];
`ifdef BA_RF_BYPASS_EN
        if (wr_acc && ra == waddr) w = wdata;
`endif
        if (BAout && ra == '0) w = '0;
        return w;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        mem_d     = mem_q;
        wr_err_d  = we && busy_q;
        rvalid_d  = ren;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;

        if (wr_acc) mem_d[waddr] = wdata;

        case (state_q)
            IDLE: begin
                if (sweep_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (ren) begin
            rdata_a_d = rd_word(raddr_a);
            rdata_b_d = rd_word(raddr_b);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            wr_err_q  <= wr_err_d;
            rvalid_q  <= rvalid_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;
    assign busy    = busy_q;
    assign wr_err  = wr_err_q;

endmodule

// File: doc/ba_register_file.md
BA_REGISTER_FILE -- requirements
Module: ba_register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 The block SHALL have parameter DEPTH, default 16, register count, power of two, >= 2; AW = log2(DEPTH) derived internally.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port we  input  1  write enable.
REQ-006 The block SHALL have port waddr  input  AW  write address.
REQ-007 The block SHALL have port wdata  input  WIDTH  write data.
REQ-008 The block SHALL have port ren  input  1  read request, both ports.
REQ-009 The block SHALL have port raddr_a / raddr_b  input  AW each  read addresses.
REQ-010 The block SHALL have port BAout  input  1  base-address select; forces register 0 to read as zero.
REQ-011 The block SHALL have port sweep_req  input  1  soft-clear request for all registers.
REQ-012 The block SHALL have port rdata_a / rdata_b  output  WIDTH each  registered read data.
REQ-013 The block SHALL have port rvalid  output  1  read data valid.
REQ-014 The block SHALL have port busy  output  1  sweep in progress.
REQ-015 The block SHALL have port wr_err  output  1  one-cycle pulse on a dropped write.

Function
REQ-016 Write: we=1, busy=0, clr=0 at an edge SHALL set mem[waddr] <= wdata; register 0 is writable storage.
REQ-017 Read latency SHALL be 1 cycle: rdata_x at cycle N+1 reflects raddr_x, BAout and contents at cycle N; rvalid(N+1) = ren(N).
REQ-018 rdata_x SHALL hold its last value while ren=0.
REQ-019 If raddr_x=0 and BAout=1 when sampled, rdata_x SHALL be all zeros; register 0 contents are unchanged. Gating applies per port, independently.
REQ-020 FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP on sweep_req=1; SWEEP->IDLE after the pointer reaches DEPTH-1.
REQ-021 In SWEEP the block SHALL zero mem[ptr] each cycle, ptr running 0..DEPTH-1; busy=1 for exactly DEPTH cycles starting the cycle after sweep_req.
REQ-022 we=1 while busy=1 SHALL be dropped, and wr_err SHALL pulse high on the following cycle.
REQ-023 sweep_req while busy=1 SHALL be ignored; the sweep SHALL NOT restart.
REQ-024 Simultaneous sweep_req and we in IDLE SHALL perform the write, then sweep; the sweep clears it.
REQ-025 Reads during SWEEP SHALL be allowed and SHALL return current contents, including already-zeroed entries.
REQ-026 Read/write collision to one address SHALL follow REQ-034/REQ-035.

Reset
REQ-027 clr=1 at an edge SHALL zero all registers, rdata_a, rdata_b, rvalid, busy, wr_err and ptr, and force IDLE.
REQ-028 clr SHALL take priority over we, ren and sweep_req in the same cycle.
REQ-029 clr during SWEEP SHALL abort the sweep; busy=0 on the next cycle.
REQ-030 Values SHALL be undefined before the first clr edge.

Configuration
REQ-031 Macro BA_RF_BYPASS_EN SHALL select the read/write collision behaviour.
REQ-032 Collision: ren=1, we=1 accepted, raddr_x = waddr, same cycle.
REQ-033 No other behaviour SHALL differ.
REQ-034 With BA_RF_BYPASS_EN defined, a collision SHALL return wdata; REQ-019 gating is then applied.
REQ-035 Without BA_RF_BYPASS_EN, a collision SHALL return the pre-write contents.

Verification
REQ-036 clr=1 one cycle after random writes -> next cycle all reads of 0..15 return 0; rvalid=0, busy=0.
REQ-037 Write 0xDEADBEEF to R0, then ren with raddr_a=0, raddr_b=0 and BAout=1 -> rdata_a=rdata_b=0; repeat with BAout=0 -> both 0xDEADBEEF.
REQ-038 Fill R0..R15 with 0x100+i, pulse sweep_req -> busy high exactly 16 cycles; we during busy gives wr_err pulse and no write; afterwards all reads are 0.
REQ-039 Pulse sweep_req, then clr on sweep cycle 5 -> busy=0 next cycle; a subsequent write to R9 with 0x55 reads back 0x55.
REQ-040 R3=0x11, then we=1, waddr=3, wdata=0x22, ren=1, raddr_a=3 in one cycle -> rdata_a=0x22 with bypass, 0x11 without; the next read gives 0x22 in both builds.
